// File: rtl/axis_master_data_gen_test.sv
// AXI4-Stream test source: after a start pulse and a fixed idle delay it emits
// NUMBER_OF_OUTPUT_WORDS beats of DATA_SEED + beat index, TLAST on the final beat,
// then raises a sticky done flag.
// Optional feature macro: THROTTLE_EN inserts a THROTTLE_GAP-cycle TVALID bubble
// after every 4th handshake that is not the last one.
`timescale 1ns/1ps
module axis_master_data_gen_test #(
  parameter int C_M_AXIS_TDATA_WIDTH   = 32,
  parameter int NUMBER_OF_OUTPUT_WORDS = 1024,
  parameter int C_M_START_COUNT        = 32,
  parameter logic [C_M_AXIS_TDATA_WIDTH-1:0] DATA_SEED = '0,
  parameter int THROTTLE_GAP           = 16,
  localparam int BC_W = $clog2(NUMBER_OF_OUTPUT_WORDS) + 1
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESET,
  input  logic                                start,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,
  output logic [BC_W-1:0]                     beat_count,
  output logic                                done
);
  localparam int W    = C_M_AXIS_TDATA_WIDTH;
  localparam int IC_W = $clog2(C_M_START_COUNT + 1);
  localparam logic [IC_W-1:0] INIT_LAST = IC_W'(C_M_START_COUNT - 1);
  localparam logic [BC_W-1:0] LAST_IDX  = BC_W'(NUMBER_OF_OUTPUT_WORDS - 1);
  localparam logic [BC_W-1:0] NWORDS    = BC_W'(NUMBER_OF_OUTPUT_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_SEND, S_GAP, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_tvalid, w_tvalid_nxt;
  logic [W-1:0]    r_tdata, w_tdata_nxt;
  logic            r_tlast, w_tlast_nxt;
  logic [BC_W-1:0] r_beat, w_beat_nxt, w_beat_inc;
  logic            r_done, w_done_nxt;
  logic [IC_W-1:0] r_init_cnt, w_init_nxt;
  logic            w_hs;

`ifdef THROTTLE_EN
  localparam int GP_W = $clog2(THROTTLE_GAP + 1);
  localparam logic [GP_W-1:0] GAP_LAST = GP_W'(THROTTLE_GAP - 1);
  logic [GP_W-1:0] r_gap_cnt, w_gap_nxt;
  logic [31:0]     w_beat32;
  assign w_beat32 = 32'(w_beat_inc);
`else
  logic w_unused_gap;
  assign w_unused_gap = ^THROTTLE_GAP;
`endif

  assign M_AXIS_TVALID = r_tvalid;
  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TLAST  = r_tlast;
  assign M_AXIS_TSTRB  = '1;
  assign beat_count    = r_beat;
  assign done          = r_done;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    w_state_nxt  = r_state;
    w_tvalid_nxt = r_tvalid;
    w_tdata_nxt  = r_tdata;
    w_tlast_nxt  = r_tlast;
    w_beat_nxt   = r_beat;
    w_done_nxt   = r_done;
    w_init_nxt   = r_init_cnt;
    w_beat_inc   = r_beat + 1'b1;
    w_hs         = r_tvalid & M_AXIS_TREADY;
`ifdef THROTTLE_EN
    w_gap_nxt    = r_gap_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_INIT;
          w_init_nxt  = '0;
        end
      end
      S_INIT: begin
        if (r_init_cnt == INIT_LAST) begin
          w_state_nxt  = S_SEND;
          w_tvalid_nxt = 1'b1;
          w_tdata_nxt  = DATA_SEED + W'(r_beat);
          w_tlast_nxt  = (r_beat == LAST_IDX);
        end else begin
          w_init_nxt = r_init_cnt + 1'b1;
        end
      end
      S_SEND: begin
        // Data only advances on a handshake, so a pending beat stays stable.
        if (w_hs) begin
          w_beat_nxt = w_beat_inc;
          if (w_beat_inc == NWORDS) begin
            w_state_nxt  = S_DONE;
            w_tvalid_nxt = 1'b0;
            w_tlast_nxt  = 1'b0;
            w_done_nxt   = 1'b1;
          end
`ifdef THROTTLE_EN
          else if (w_beat32[1:0] == 2'b00) begin
            w_state_nxt  = S_GAP;
            w_tvalid_nxt = 1'b0;
            w_tlast_nxt  = 1'b0;
            w_gap_nxt    = '0;
          end
`endif
          else begin
            w_tdata_nxt = DATA_SEED + W'(w_beat_inc);
            w_tlast_nxt = (w_beat_inc == LAST_IDX);
          end
        end
      end
`ifdef THROTTLE_EN
      S_GAP: begin
        // Bubble length is independent of TREADY.
        if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt  = S_SEND;
          w_tvalid_nxt = 1'b1;
          w_tdata_nxt  = DATA_SEED + W'(r_beat);
          w_tlast_nxt  = (r_beat == LAST_IDX);
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
`endif
      S_DONE: begin
        if (start) begin
          w_state_nxt = S_INIT;
          w_init_nxt  = '0;
          w_done_nxt  = 1'b0;
          w_beat_nxt  = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      r_state    <= S_IDLE;
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
      r_tlast    <= 1'b0;
      r_beat     <= '0;
      r_done     <= 1'b0;
      r_init_cnt <= '0;
`ifdef THROTTLE_EN
      r_gap_cnt  <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_tvalid   <= w_tvalid_nxt;
      r_tdata    <= w_tdata_nxt;
      r_tlast    <= w_tlast_nxt;
      r_beat     <= w_beat_nxt;
      r_done     <= w_done_nxt;
      r_init_cnt <= w_init_nxt;
`ifdef THROTTLE_EN
      r_gap_cnt  <= w_gap_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_axis_master_data_gen_test.sv
// Directed bench for axis_master_data_gen_test: scoreboard of expected beats,
// handshake-stability and bubble-length checks, reset and start corner cases.
`timescale 1ns/1ps
module tb_axis_master_data_gen_test;
  localparam int W   = 32;
  localparam int N   = 1024;
  localparam int SC  = 32;
  localparam int G   = 16;
  localparam int BCW = $clog2(N) + 1;
  localparam int N2  = 4;
  localparam int SC2 = 3;
  localparam int BCW2 = $clog2(N2) + 1;
`ifdef THROTTLE_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, tready, start2, tready2;
  logic tvalid, tlast, done, tvalid2, tlast2, done2;
  logic [W-1:0] tdata, tdata2;
  logic [W/8-1:0] tstrb, tstrb2;
  logic [BCW-1:0] beat_count;
  logic [BCW2-1:0] beat_count2;

  int errors = 0;
  int checks = 0;

  typedef struct packed { logic [W-1:0] d; logic l; } beat_t;
  beat_t sb[$];

  always #5 clk = ~clk;

  axis_master_data_gen_test #(
    .C_M_AXIS_TDATA_WIDTH(W), .NUMBER_OF_OUTPUT_WORDS(N), .C_M_START_COUNT(SC),
    .DATA_SEED(32'h0), .THROTTLE_GAP(G)
  ) dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst), .start(start),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb),
    .M_AXIS_TLAST(tlast), .M_AXIS_TREADY(tready), .beat_count(beat_count), .done(done)
  );

  axis_master_data_gen_test #(
    .C_M_AXIS_TDATA_WIDTH(W), .NUMBER_OF_OUTPUT_WORDS(N2), .C_M_START_COUNT(SC2),
    .DATA_SEED(32'hFFFF_FFFE), .THROTTLE_GAP(G)
  ) dut2 (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst), .start(start2),
    .M_AXIS_TVALID(tvalid2), .M_AXIS_TDATA(tdata2), .M_AXIS_TSTRB(tstrb2),
    .M_AXIS_TLAST(tlast2), .M_AXIS_TREADY(tready2), .beat_count(beat_count2), .done(done2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input int n, input logic [W-1:0] seed);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.d = seed + W'(i);
      b.l = (i == n - 1);
      sb.push_back(b);
    end
  endtask

  // mode 0: TREADY=1; mode 1: TREADY alternates. abort_at>0: reset after that
  // many handshakes. poke_at>0: pulse start mid-stream. poke_init: pulse start
  // while the init delay is counting.
  task automatic run_burst(input int mode, input int abort_at, input int poke_at, input bit poke_init);
    int hs = 0, low_run = 0, cyc = 0, lat = 1, exp_gap = 0;
    bit pend = 0, awaiting = 0;
    logic [W-1:0] pd;
    logic pl;
    beat_t e;
    sb.delete();
    push_burst(N, 32'h0);
    tready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!tvalid && lat < SC + 50) begin
      start = (poke_init && lat == 5);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("first_tvalid_latency", lat, SC + 1);
    while (hs < N && cyc < 20000) begin
      cyc++;
      start = 1'b0;
      if (pend) begin
        chk("pending_tvalid", tvalid, 1'b1);
        chk("pending_tdata", tdata, pd);
        chk("pending_tlast", tlast, pl);
      end
      if (tvalid && awaiting) begin
        chk("bubble_len", low_run, exp_gap);
        awaiting = 0;
      end
      if (!tvalid) low_run++;
      if (abort_at > 0 && hs == abort_at) begin
        tready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_tvalid", tvalid, 1'b0);
        chk("abort_beat_count", beat_count, 0);
        chk("abort_done", done, 1'b0);
        chk("abort_tdata", tdata, 0);
        sb.delete();
        repeat (SC + 5) @(negedge clk);
        chk("abort_stays_idle", tvalid, 1'b0);
        return;
      end
      tready = (mode == 0) ? 1'b1 : cyc[0];
      if (poke_at > 0 && hs == poke_at) start = 1'b1;
      pend = 0;
      if (tvalid && tready) begin
        chk("beat_count_at_hs", beat_count, hs);
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("tdata", tdata, e.d);
          chk("tlast", tlast, e.l);
        end
        hs++;
        awaiting = 1;
        low_run = 0;
        exp_gap = (THR && (hs % 4 == 0) && hs < N) ? G : 0;
      end else if (tvalid) begin
        pend = 1;
        pd = tdata;
        pl = tlast;
      end
      @(negedge clk);
    end
    start = 1'b0;
    tready = 1'b0;
    chk("handshakes", hs, N);
    chk("end_tvalid", tvalid, 1'b0);
    chk("end_tlast", tlast, 1'b0);
    chk("end_done", done, 1'b1);
    chk("end_beat_count", beat_count, N);
    chk("sb_empty", sb.size(), 0);
    tready = 1'b1;
    repeat (4) @(negedge clk);
    chk("done_sticky", done, 1'b1);
    chk("no_beat_after_done", tvalid, 1'b0);
    tready = 1'b0;
  endtask

  initial begin
    int hs2, cyc2, lat2;
    beat_t e;
    rst = 1'b1; start = 1'b0; tready = 1'b0; start2 = 1'b0; tready2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_tdata", tdata, 0);
    chk("rst_beat_count", beat_count, 0);
    chk("rst_done", done, 1'b0);
    chk("tstrb", tstrb, 4'hF);
    chk("rst2_tvalid", tvalid2, 1'b0);
    repeat (6) @(negedge clk);

    // Full burst, TREADY high, with a start pulse during the init delay.
    run_burst(0, 0, 0, 1'b1);
    // Start from DONE, alternating TREADY.
    run_burst(1, 0, 0, 1'b0);
    // Reset mid-burst, then restart from beat 0.
    run_burst(0, 500, 0, 1'b0);
    run_burst(0, 0, 0, 1'b0);
    // Start ignored mid-stream, then a second identical burst from DONE.
    run_burst(0, 0, 100, 1'b0);
    run_burst(0, 0, 0, 1'b0);

    // Reset and start together: start is lost.
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_done", done, 1'b0);
    repeat (SC + 10) @(negedge clk);
    chk("rst_start_idle", tvalid, 1'b0);
    chk("rst_start_beat_count", beat_count, 0);

    // Short burst with wrapping seed.
    sb.delete();
    push_burst(N2, 32'hFFFF_FFFE);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat2 = 1;
    while (!tvalid2 && lat2 < 50) begin lat2++; @(negedge clk); end
    chk("short_latency", lat2, SC2 + 1);
    hs2 = 0; cyc2 = 0;
    tready2 = 1'b1;
    while (hs2 < N2 && cyc2 < 200) begin
      cyc2++;
      if (tvalid2) begin
        e = sb.pop_front();
        chk("short_tdata", tdata2, e.d);
        chk("short_tlast", tlast2, e.l);
        hs2++;
      end
      @(negedge clk);
    end
    tready2 = 1'b0;
    chk("short_handshakes", hs2, N2);
    chk("short_done", done2, 1'b1);
    chk("short_tvalid_end", tvalid2, 1'b0);
    chk("short_beat_count", beat_count2, N2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
